onehalf_dt_driver: RTL and testbench
====================================

ONEHALF_DT_DRIVER -- requirements
Module: onehalf_dt_driver

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent 1.5-bit channels, legal range 1..16.
REQ-002 SHALL have parameter DEAD_CYCLES, default 4: both-off cycles inserted on every P/N turn-off, legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: fault counter width.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1: synchronous global run enable; low forces all channels to off.
REQ-007 SHALL have port in_p  in  CHANNELS: per-channel high-side comparator request.
REQ-008 SHALL have port in_n  in  CHANNELS: per-channel low-side comparator request.
REQ-009 SHALL have port out_p  out  CHANNELS: per-channel high-side gate drive, registered.
REQ-010 SHALL have port out_n  out  CHANNELS: per-channel low-side gate drive, registered.
REQ-011 SHALL have port dead_active  out  CHANNELS: per-channel flag, high while the channel is in DEAD.

Function
REQ-012 SHALL register in_p/in_n each cycle (stage 1); decode per channel: 10=REQ_P, 01=REQ_N, 00=REQ_OFF, 11=REQ_OFF (forbidden).
REQ-013 SHALL run one FSM per channel with states OFF, P_ON, N_ON, DEAD and an 8-bit dead counter.
REQ-014 SHALL transition OFF->P_ON on REQ_P, OFF->N_ON on REQ_N, and otherwise stay OFF.
REQ-015 SHALL stay in P_ON on REQ_P and go P_ON->DEAD on REQ_N or REQ_OFF, loading the counter with DEAD_CYCLES; N_ON is symmetric.
REQ-016 SHALL decrement the counter each DEAD cycle; at count 1 the next state is the decoded request (P_ON/N_ON/OFF), so exactly DEAD_CYCLES both-off cycles elapse.
REQ-017 SHALL always run DEAD to completion, including when the request returns to the same side.
REQ-018 SHALL drive out_p=1 only in P_ON, out_n=1 only in N_ON, dead_active=1 only in DEAD; out_p&out_n SHALL never be 1 on any channel in any cycle.
REQ-019 Latency: an input change sampled at edge k SHALL appear on outputs after edge k+1 when the channel is in OFF (2 cycles pin-to-pin).
REQ-020 With enable=0, the request SHALL be treated as REQ_OFF: P_ON/N_ON go to DEAD, then OFF, and remain OFF; a DEAD in progress completes normally.
REQ-021 Channels SHALL be fully independent apart from sharing enable.

Reset
REQ-022 rst_n low SHALL asynchronously clear the input registers and counters, set every FSM to OFF, and force out_p=0, out_n=0, dead_active=0 (and fault_cnt=0), including mid-DEAD.
REQ-023 The first post-reset transition SHALL occur no earlier than the second rising edge after rst_n deasserts.

Configuration
REQ-024 With ONEHALF_FAULT_CNT_EN defined, SHALL add ports fault_clr (in 1) and fault_cnt (out CNT_W); fault_cnt increments once per cycle in which any channel's stage-1 input is 11, saturates at all-ones, and fault_clr clears it synchronously, with clear winning over increment.
REQ-025 Without ONEHALF_FAULT_CNT_EN, those ports and the counter SHALL be absent; 11 is still decoded as REQ_OFF.

Structure
REQ-026 Package onehalf_pkg SHALL hold the FSM state enum, the request-decode enum, and the dead-counter width constant (8).
REQ-027 Sub-module onehalf_dt_channel (one FSM, counter, and output registers) SHALL be instantiated CHANNELS times in a generate loop; decode, enable gating, and the fault counter live at top level.

Verification
REQ-028 Reset, then enable=1 and ch0 in=10 -> out_p[0]=1 two edges later; out_n[0]=0 throughout.
REQ-029 DEAD_CYCLES=4, ch0 in P_ON, in switched to 01 -> out_p=0, dead_active=1 for exactly 4 cycles, then out_n=1.
REQ-030 During DEAD, in returns to 10 -> DEAD still lasts 4 cycles, then P_ON; no out_n pulse.
REQ-031 in=11 held for 5 cycles on ch1 with the macro defined -> ch1 outputs off; fault_cnt=5; fault_clr pulsed together with 11 -> fault_cnt=0; CNT_W=2 with 6 faults -> fault_cnt=3.
REQ-032 enable dropped while ch0 is P_ON and ch1 is N_ON -> both pass through 4-cycle DEAD to OFF and stay OFF despite in=10/01.
REQ-033 rst_n asserted mid-DEAD -> all outputs 0 immediately (asynchronous); random stimulus on 4 channels for 10k cycles -> an assertion that out_p&out_n is never 1 and that every P<->N swap has at least DEAD_CYCLES both-off cycles.

Source files
------------

// File: rtl/onehalf_pkg.sv
// +-----------------------------------------------------------------------+
// | onehalf_pkg : shared types and constants for the 1.5-bit driver       |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

package onehalf_pkg;

    localparam int DEAD_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_P_ON = 2'd1,
        ST_N_ON = 2'd2,
        ST_DEAD = 2'd3
    } ch_state_e;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_P   = 2'd1,
        REQ_N   = 2'd2
    } req_e;

    // 11 is forbidden on the comparator pair and is treated as a turn-off
    function automatic req_e decode_req(input logic p, input logic n);
        if (p && !n) begin
            return REQ_P;
        end else if (!p && n) begin
            return REQ_N;
        end
        return REQ_OFF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehalf_dt_channel.sv
// +-----------------------------------------------------------------------+
// | onehalf_dt_channel : one dead-time FSM with registered gate outputs   |
// | Revision           : 1.0                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module onehalf_dt_channel
    import onehalf_pkg::*;
#(
    parameter int DEAD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  req_e req_i,
    output logic out_p_o,
    output logic out_n_o,
    output logic dead_active_o
);

    localparam logic [DEAD_CNT_W-1:0] c_dead_load = DEAD_CNT_W'(DEAD_CYCLES);

    ch_state_e             state_q, state_d;
    logic [DEAD_CNT_W-1:0] cnt_q, cnt_d;
    logic                  out_p_q, out_n_q, dead_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (req_i == REQ_P) begin
                    state_d = ST_P_ON;
                end else if (req_i == REQ_N) begin
                    state_d = ST_N_ON;
                end
            end
            ST_P_ON: begin
                if (req_i != REQ_P) begin
                    state_d = ST_DEAD;
                    cnt_d   = c_dead_load;
                end
            end
            ST_N_ON: begin
                if (req_i != REQ_N) begin
                    state_d = ST_DEAD;
                    cnt_d   = c_dead_load;
                end
            end
            ST_DEAD: begin
                // Last dead cycle hands over to whatever is requested now
                if (cnt_q <= DEAD_CNT_W'(1)) begin
                    cnt_d = '0;
                    case (req_i)
                        REQ_P:   state_d = ST_P_ON;
                        REQ_N:   state_d = ST_N_ON;
                        default: state_d = ST_OFF;
                    endcase
                end else begin
                    cnt_d = cnt_q - DEAD_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            out_p_q <= 1'b0;
            out_n_q <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_p_q <= (state_d == ST_P_ON);
            out_n_q <= (state_d == ST_N_ON);
            dead_q  <= (state_d == ST_DEAD);
        end
    end

    assign out_p_o       = out_p_q;
    assign out_n_o       = out_n_q;
    assign dead_active_o = dead_q;

endmodule

`default_nettype wire

// File: rtl/onehalf_dt_driver.sv
// +-----------------------------------------------------------------------+
// | onehalf_dt_driver : multi-channel 1.5-bit gate driver with dead time  |
// | Option ONEHALF_FAULT_CNT_EN adds fault_clr/fault_cnt. Revision : 1.0  |
// +-----------------------------------------------------------------------+
`default_nettype none

module onehalf_dt_driver
    import onehalf_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DEAD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] in_p,
    input  logic [CHANNELS-1:0] in_n,
`ifdef ONEHALF_FAULT_CNT_EN
    input  logic                fault_clr,
    output logic [CNT_W-1:0]    fault_cnt,
`endif
    output logic [CHANNELS-1:0] out_p,
    output logic [CHANNELS-1:0] out_n,
    output logic [CHANNELS-1:0] dead_active
);

    logic [CHANNELS-1:0] in_p_q, in_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_p_q <= '0;
            in_n_q <= '0;
        end else begin
            in_p_q <= in_p;
            in_n_q <= in_n;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        req_e w_req;

        assign w_req = enable ? decode_req(in_p_q[i], in_n_q[i]) : REQ_OFF;

        onehalf_dt_channel #(
            .DEAD_CYCLES (DEAD_CYCLES)
        ) u_channel (
            .clk           (clk),
            .rst_n         (rst_n),
            .req_i         (w_req),
            .out_p_o       (out_p[i]),
            .out_n_o       (out_n[i]),
            .dead_active_o (dead_active[i])
        );
    end

`ifdef ONEHALF_FAULT_CNT_EN
    logic             w_fault_any;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    assign w_fault_any = |(in_p_q & in_n_q);

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (fault_clr) begin
            fault_cnt_d = '0;
        end else if (w_fault_any && (fault_cnt_q != {CNT_W{1'b1}})) begin
            fault_cnt_d = fault_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_cnt = fault_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_onehalf_dt_driver.sv
// +-----------------------------------------------------------------------+
// | tb_onehalf_dt_driver : self-checking bench for onehalf_dt_driver      |
// | Revision             : 1.0                                            |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_onehalf_dt_driver;

    localparam int CH = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [CH-1:0] in_p, in_n;
    logic [CH-1:0] out_p, out_n, dead_active;
    logic          fault_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

`ifdef ONEHALF_FAULT_CNT_EN
    logic [7:0] fault_cnt;
    logic [1:0] fault_cnt2;
    logic [1:0] out_p2, out_n2, dead2;

    onehalf_dt_driver #(.CHANNELS(CH), .DEAD_CYCLES(D), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_p(in_p), .in_n(in_n),
        .fault_clr(fault_clr), .fault_cnt(fault_cnt),
        .out_p(out_p), .out_n(out_n), .dead_active(dead_active));

    onehalf_dt_driver #(.CHANNELS(2), .DEAD_CYCLES(D), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_p(in_p[1:0]), .in_n(in_n[1:0]),
        .fault_clr(fault_clr), .fault_cnt(fault_cnt2),
        .out_p(out_p2), .out_n(out_n2), .dead_active(dead2));
`else
    onehalf_dt_driver #(.CHANNELS(CH), .DEAD_CYCLES(D), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_p(in_p), .in_n(in_n),
        .out_p(out_p), .out_n(out_n), .dead_active(dead_active));
`endif

    // Reference model: drive is +1 (high side), -1 (low side) or 0; dead_left
    // counts remaining both-off cycles after a turn-off.
    logic [CH-1:0] m_s1p, m_s1n;
    int            m_drive [CH];
    int            m_dead  [CH];
    int            m_f8, m_f2;
    int            last_side [CH];
    int            off_run   [CH];

    task automatic model_reset();
        m_s1p = '0;
        m_s1n = '0;
        m_f8  = 0;
        m_f2  = 0;
        for (int i = 0; i < CH; i++) begin
            m_drive[i]   = 0;
            m_dead[i]    = 0;
            last_side[i] = 0;
            off_run[i]   = D;
        end
    endtask

    task automatic model_step();
        int r;
        for (int i = 0; i < CH; i++) begin
            r = 0;
            if (enable && m_s1p[i] && !m_s1n[i]) r = 1;
            if (enable && !m_s1p[i] && m_s1n[i]) r = -1;
            if (m_dead[i] > 0) begin
                if (m_dead[i] == 1) begin
                    m_dead[i]  = 0;
                    m_drive[i] = r;
                end else begin
                    m_dead[i] = m_dead[i] - 1;
                end
            end else if (m_drive[i] == 0) begin
                m_drive[i] = r;
            end else if (r != m_drive[i]) begin
                m_drive[i] = 0;
                m_dead[i]  = D;
            end
        end
        if (fault_clr) begin
            m_f8 = 0;
            m_f2 = 0;
        end else begin
            if ((|(m_s1p & m_s1n)) && m_f8 < 255) m_f8++;
            if ((|(m_s1p[1:0] & m_s1n[1:0])) && m_f2 < 3) m_f2++;
        end
        m_s1p = in_p;
        m_s1n = in_n;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [CH-1:0] ep, en, ed;
        for (int i = 0; i < CH; i++) begin
            ep[i] = (m_drive[i] == 1);
            en[i] = (m_drive[i] == -1);
            ed[i] = (m_dead[i] > 0);
        end
        chk("model_out_p", 32'(out_p), 32'(ep));
        chk("model_out_n", 32'(out_n), 32'(en));
        chk("model_dead", 32'(dead_active), 32'(ed));
`ifdef ONEHALF_FAULT_CNT_EN
        chk("model_fault_cnt", 32'(fault_cnt), 32'(m_f8));
        chk("model_fault_cnt_w2", 32'(fault_cnt2), 32'(m_f2));
        chk("model_out_p_w2", 32'(out_p2), 32'(ep[1:0]));
        chk("model_out_n_w2", 32'(out_n2), 32'(en[1:0]));
`endif
    endtask

    // Overlap and minimum both-off gap between opposite-side conductions
    task automatic gap_check();
        int side;
        checks++;
        assert ((out_p & out_n) == '0) else begin
            errors++;
            $display("FAIL overlap: out_p=0x%0h out_n=0x%0h at %0t", out_p, out_n, $time);
        end
        for (int i = 0; i < CH; i++) begin
            side = out_p[i] ? 1 : (out_n[i] ? -1 : 0);
            if (side != 0) begin
                if (last_side[i] != 0 && side != last_side[i] && off_run[i] < D) begin
                    errors++;
                    $display("FAIL dead_gap ch%0d: got %0d off cycles expected >= %0d", i, off_run[i], D);
                end
                last_side[i] = side;
                off_run[i]   = 0;
            end else begin
                off_run[i]++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        gap_check();
        check_model();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        in_p      = '0;
        in_n      = '0;
        fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        chk("reset_out_p", 32'(out_p), 32'd0);
        chk("reset_out_n", 32'(out_n), 32'd0);
        chk("reset_dead", 32'(dead_active), 32'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic p;
        logic n;
        logic ep;
        logic en;
        logic ed;
    } vec_t;

    vec_t tbl [25];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ch0 only: {in_p, in_n} -> expected {out_p, out_n, dead_active} after the edge
        tbl[0]  = '{1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 1};
        tbl[4]  = '{0, 1, 0, 0, 1};
        tbl[5]  = '{0, 1, 0, 0, 1};
        tbl[6]  = '{0, 1, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 1, 0};
        tbl[8]  = '{1, 0, 0, 1, 0};
        tbl[9]  = '{1, 0, 0, 0, 1};
        tbl[10] = '{0, 1, 0, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 1};
        tbl[12] = '{0, 1, 0, 0, 1};
        tbl[13] = '{0, 1, 0, 1, 0};
        tbl[14] = '{1, 0, 0, 1, 0};
        tbl[15] = '{0, 1, 0, 0, 1};
        tbl[16] = '{1, 0, 0, 0, 1};
        tbl[17] = '{1, 0, 0, 0, 1};
        tbl[18] = '{1, 0, 0, 0, 1};
        tbl[19] = '{1, 1, 1, 0, 0};
        tbl[20] = '{0, 0, 0, 0, 1};
        tbl[21] = '{0, 0, 0, 0, 1};
        tbl[22] = '{0, 0, 0, 0, 1};
        tbl[23] = '{0, 0, 0, 0, 1};
        tbl[24] = '{0, 0, 0, 0, 0};

        do_reset();

`ifdef ONEHALF_FAULT_CNT_EN
        enable    = 1'b1;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        in_p      = 4'b0010;
        in_n      = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("fault_ch1_p_off", 32'(out_p[1]), 32'd0);
            chk("fault_ch1_n_off", 32'(out_n[1]), 32'd0);
        end
        in_p = '0;
        in_n = '0;
        tick();
        chk("fault_cnt_5", 32'(fault_cnt), 32'd5);
        chk("fault_cnt_w2_sat", 32'(fault_cnt2), 32'd3);
        in_p = 4'b0010;
        in_n = 4'b0010;
        tick();
        in_p = '0;
        in_n = '0;
        tick();
        chk("fault_cnt_6", 32'(fault_cnt), 32'd6);
        chk("fault_cnt_w2_6", 32'(fault_cnt2), 32'd3);
        in_p = 4'b0010;
        in_n = 4'b0010;
        tick();
        fault_clr = 1'b1;
        tick();
        chk("fault_clr_wins", 32'(fault_cnt), 32'd0);
        chk("fault_clr_wins_w2", 32'(fault_cnt2), 32'd0);
        fault_clr = 1'b0;
        in_p      = '0;
        in_n      = '0;
        tick();
        tick();
        do_reset();
`endif

        enable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            in_p[0] = tbl[k].p;
            in_n[0] = tbl[k].n;
            tick();
            chk($sformatf("tbl%0d_out_p", k), 32'(out_p[0]), 32'(tbl[k].ep));
            chk($sformatf("tbl%0d_out_n", k), 32'(out_n[0]), 32'(tbl[k].en));
            chk($sformatf("tbl%0d_dead", k), 32'(dead_active[0]), 32'(tbl[k].ed));
        end

        // enable dropped with ch0 high-side and ch1 low-side conducting
        in_p = 4'b0001;
        in_n = 4'b0010;
        tick();
        tick();
        chk("en_pre_out_p", 32'(out_p[1:0]), 32'b01);
        chk("en_pre_out_n", 32'(out_n[1:0]), 32'b10);
        enable = 1'b0;
        for (int k = 0; k < D; k++) begin
            tick();
            chk("en_dead", 32'(dead_active[1:0]), 32'b11);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("en_off_p", 32'(out_p[1:0]), 32'b00);
            chk("en_off_n", 32'(out_n[1:0]), 32'b00);
            chk("en_off_dead", 32'(dead_active[1:0]), 32'b00);
        end

        // asynchronous reset while ch2 is in its dead window
        enable = 1'b1;
        in_p   = 4'b0100;
        in_n   = '0;
        tick();
        tick();
        in_p = '0;
        tick();
        tick();
        chk("mid_dead_entered", 32'(dead_active[2]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_p", 32'(out_p), 32'd0);
        chk("async_out_n", 32'(out_n), 32'd0);
        chk("async_dead", 32'(dead_active), 32'd0);
        do_reset();

        // randomized run, mostly held requests so channels dwell in P/N
        enable = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_p = CH'($urandom);
                in_n = CH'($urandom);
            end
            enable    = ($urandom_range(0, 15) != 0);
            fault_clr = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
